// File: rtl/a3_tpgen.sv
// Time-pulse generator: synchronizes the odd/even timer strobes, turns their edges into ticks,
// and steps a ZERO/T01..T12/HALT sequencer that drives a one-hot TP bus and a memory-cycle count.
module a3_tpgen #(
    parameter bit STOP_AT_T12 = 1'b1
) (
    input  logic        SIM_CLK,
    input  logic        SIM_RST,
    input  logic        ODDSET_,
    input  logic        EVNSET,
    input  logic        STOP,
    input  logic        GOJAM,
    output logic [11:0] TP,
    output logic        TPZERO,
    output logic        STOPPED,
    output logic        MCTEND,
    output logic [15:0] MCTCNT
);

    typedef enum logic [3:0] {
        StZero = 4'd0,
        StT01  = 4'd1,
        StT02  = 4'd2,
        StT03  = 4'd3,
        StT04  = 4'd4,
        StT05  = 4'd5,
        StT06  = 4'd6,
        StT07  = 4'd7,
        StT08  = 4'd8,
        StT09  = 4'd9,
        StT10  = 4'd10,
        StT11  = 4'd11,
        StT12  = 4'd12,
        StHalt = 4'd13
    } state_e;

    state_e      state_q, state_d;
    logic        odd_s1_q, odd_s2_q, odd_prev_q;
    logic        evn_s1_q, evn_s2_q, evn_prev_q;
    logic [1:0]  arm_cnt_q;
    logic        armed;
    logic        tick;
    logic [11:0] tp_q, tp_d;
    logic        mct_end_q, mct_end_d;
    logic [15:0] mct_cnt_q;

    // Two-flop synchronizers plus previous-value registers for edge detection. The arm counter
    // keeps edge detection off until prev has caught up with the synchronized level, so a strobe
    // level already present when reset drops is not mistaken for an edge.
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            odd_s1_q   <= 1'b1;
            odd_s2_q   <= 1'b1;
            odd_prev_q <= 1'b1;
            evn_s1_q   <= 1'b0;
            evn_s2_q   <= 1'b0;
            evn_prev_q <= 1'b0;
            arm_cnt_q  <= 2'd0;
        end else begin
            odd_s1_q   <= ODDSET_;
            odd_s2_q   <= odd_s1_q;
            odd_prev_q <= odd_s2_q;
            evn_s1_q   <= EVNSET;
            evn_s2_q   <= evn_s1_q;
            evn_prev_q <= evn_s2_q;
            if (arm_cnt_q != 2'd3) begin
                arm_cnt_q <= arm_cnt_q + 2'd1;
            end
        end
    end

    assign armed = (arm_cnt_q == 2'd3);
    // OR of the two edges: coincident odd and even edges still make a single tick.
    assign tick  = armed & ((odd_prev_q & ~odd_s2_q) | (evn_s2_q & ~evn_prev_q));

    // Next-state, cycle-end pulse and one-hot TP decode of the next state.
    always_comb begin
        state_d   = state_q;
        mct_end_d = 1'b0;
        if (GOJAM) begin
            state_d = StZero;
        end else if (tick) begin
            case (state_q)
                StZero: state_d = StT01;
                StT12: begin
                    state_d   = STOP ? StHalt : StT01;
                    mct_end_d = 1'b1;
                end
                StHalt: state_d = STOP ? StHalt : StT01;
                StT01, StT02, StT03, StT04, StT05, StT06,
                StT07, StT08, StT09, StT10, StT11: begin
                    if (STOP && !STOP_AT_T12) begin
                        state_d = StHalt;
                    end else begin
                        state_d = state_e'(state_q + 4'd1);
                    end
                end
                default: state_d = StZero;
            endcase
        end
        tp_d = '0;
        for (int i = 0; i < 12; i++) begin
            tp_d[i] = (state_d == state_e'(4'(i + 1)));
        end
    end

    // State, TP, cycle-end pulse and memory-cycle counter registers.
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            state_q   <= StZero;
            tp_q      <= '0;
            mct_end_q <= 1'b0;
            mct_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tp_q      <= tp_d;
            mct_end_q <= mct_end_d;
            if (mct_end_d) begin
                mct_cnt_q <= mct_cnt_q + 16'd1;
            end
        end
    end

    assign TP      = tp_q;
    assign TPZERO  = (state_q == StZero);
    assign STOPPED = (state_q == StHalt);
    assign MCTEND  = mct_end_q;
    assign MCTCNT  = mct_cnt_q;

endmodule

// File: doc/a3_tpgen.md
A3_TPGEN -- requirements
Module: a3_tpgen

Interface
REQ-001 Parameter STOP_AT_T12, default 1: 1 means a stop request is honoured only at the T12->T01 boundary; 0 means a stop request is honoured at the next tick.
REQ-002 Port SIM_CLK, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 Port SIM_RST, input, 1 bit: reset, asynchronous, active-high.
REQ-004 Port ODDSET_, input, 1 bit: timer odd-set strobe, active-low, asynchronous to SIM_CLK.
REQ-005 Port EVNSET, input, 1 bit: timer even-set strobe, active-high, asynchronous to SIM_CLK.
REQ-006 Port STOP, input, 1 bit: stop request, level.
REQ-007 Port GOJAM, input, 1 bit: restart request, level, synchronous.
REQ-008 Port TP, output, 12 bits: one-hot time pulse; bit n-1 means Tn.
REQ-009 Port TPZERO, output, 1 bit: high while in state ZERO.
REQ-010 Port STOPPED, output, 1 bit: high while in state HALT.
REQ-011 Port MCTEND, output, 1 bit: one-cycle pulse on each T12->T01 or T12->HALT transition.
REQ-012 Port MCTCNT, output, 16 bits: count of completed memory cycles.

Function
REQ-013 ODDSET_ and EVNSET SHALL each pass through a 2-flop synchronizer, followed by a registered previous value used for edge detection.
REQ-014 A tick SHALL be either a synchronized ODDSET_ falling edge or a synchronized EVNSET rising edge.
REQ-015 Coincident odd and even edges in one SIM_CLK cycle SHALL produce exactly one tick.
REQ-016 The state machine SHALL have 14 states: ZERO, T01..T12, HALT.
REQ-017 On a tick, ZERO SHALL go to T01, and Tn SHALL go to Tn+1 for n<12.
REQ-018 On a tick, T12 SHALL go to HALT if STOP=1, else to T01.
REQ-019 On a tick, HALT SHALL go to T01 if STOP=0, else stay in HALT.
REQ-020 When STOP_AT_T12=0, a tick in any Tn with STOP=1 SHALL go to HALT.
REQ-021 With no tick, the state SHALL hold.
REQ-022 TP SHALL be registered, one-hot in T01..T12, and all-zero in ZERO and HALT.
REQ-023 TP SHALL change in the cycle after the tick is detected; total latency from a raw strobe edge SHALL be at most 4 SIM_CLK cycles.
REQ-024 GOJAM=1 SHALL force ZERO on the next edge, overriding any tick, and SHALL hold ZERO while asserted.
REQ-025 After GOJAM deasserts, the first tick SHALL go to T01.
REQ-026 MCTEND SHALL pulse high for exactly one cycle, registered, coincident with TP leaving bit 11.
REQ-027 MCTCNT SHALL increment by 1 on each MCTEND, mod 2^16 (0xFFFF wraps to 0x0000), with no overflow flag.
REQ-028 GOJAM SHALL NOT clear MCTCNT.
REQ-029 A GOJAM that takes effect while in T12 with a tick present SHALL suppress MCTEND and the MCTCNT increment.

Reset
REQ-030 While SIM_RST=1: state=ZERO, TP=0x000, TPZERO=1, STOPPED=0, MCTEND=0, MCTCNT=0x0000, synchronizers and edge registers cleared to the inactive strobe level (ODDSET_=1, EVNSET=0).
REQ-031 When SIM_RST is asserted mid-cycle in any state, the outputs SHALL take their reset values asynchronously.
REQ-032 After SIM_RST deasserts, a strobe level already present SHALL NOT create a tick; a fresh edge is required.

Verification
REQ-033 After reset, 12 alternating ODDSET_/EVNSET edges -> TP walks 0x001..0x800, one bit per tick; the 13th tick -> TP=0x001, one-cycle MCTEND, MCTCNT=1.
REQ-034 STOP=1 held through T12, then a tick -> TP=0x000, STOPPED=1, MCTEND pulses once; further ticks with STOP=1 -> no change; STOP=0 plus a tick -> TP=0x001, STOPPED=0.
REQ-035 GOJAM pulsed in T07 -> TP=0x000, TPZERO=1, MCTCNT unchanged; the next tick -> TP=0x001.
REQ-036 ODDSET_ fall and EVNSET rise arriving in the same SIM_CLK cycle -> state advances exactly one position.
REQ-037 MCTCNT preloaded to 0xFFFF by running 65535 cycles, then one more T12->T01 -> MCTCNT=0x0000.
REQ-038 SIM_RST asserted in T05 while EVNSET=1 -> TP=0x000 immediately; SIM_RST released with EVNSET still 1 -> no tick until EVNSET falls and rises again.
